dffram_32x4_2r1w: RTL and testbench
===================================

Name: dffram_32x4_2r1w

Overview:
- 32-word x 4-bit flip-flop RAM with two read ports (A, B) and one write port, packaged as a TinyTapeout user tile.
- The write port shares its address with read port A.
- Both read ports are fully independent and can read any word every cycle.
- Sits directly behind the tile pins; uio pins are inputs only.

Parameters:
- DEPTH, 32, number of words; only the default is supported by the pin map.
- ADDR_W, 5, address width (log2 DEPTH).
- DATA_W, 4, word width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  tile enable; writes only occur while ena=1.
- ui_in  input  8  [4:0] address A (read port A and write address); [7:5] address B bits [2:0].
- uio_in  input  8  [1:0] address B bits [4:3]; [5:2] write data; [6] write enable (we); [7] unused, ignored.
- uo_out  output  8  [3:0] read data A; [7:4] read data B.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all uio pins are inputs).

Behaviour:
- Storage: 32 x 4-bit registers mem[0..31].
- Reset: on a rising clk edge with rst_n=0, every mem word is cleared to 0. Reset has priority over a write in the same cycle. After reset, uo_out=0x00 for any addresses.
- Write: on a rising clk edge with rst_n=1, ena=1 and we=1, mem[addrA] <= wdata. No write occurs if ena=0 or we=0.
- Read A: uo_out[3:0] = mem[addrA], combinational (zero latency from address change).
- Read B: uo_out[7:4] = mem[addrB], combinational.
- Read-during-write, same address:
  - Before the edge, the read ports show the old word.
  - From the edge onward, they show the new word.
  - There is no combinational bypass of wdata.
- addrA == addrB is legal; both nibbles show the same word.
- All 5-bit addresses are valid; there is no out-of-range case and no wrap logic.
- uio_in[7] has no effect on any behaviour.
- uio_out and uio_oe are 0 in all states, including during reset.

Optional Feature:
- Macro: DFFRAM_REGISTERED_READ_EN.
- Defined:
  - uo_out is driven from an 8-bit output register loaded every rising edge with {mem[addrB], mem[addrA]}, sampled before the same-edge write (read-before-write).
  - Read latency is 1 clock.
  - The output register clears to 0 on reset.
- Not defined: combinational reads as above, latency 0.
- The write path is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks, then set addrA=0 and addrB=31 -> uo_out=0x00; uio_out=0x00; uio_oe=0x00.
- Single write/read: ena=1, addrA=3, wdata=0xA, we=1, one clock; then we=0, addrA=3, addrB=3 -> uo_out=0xAA.
- Fill/dual read: for n=0..31 write (n*7+1)&0xF to addr n; then sweep addrA=n, addrB=31-n -> uo_out[3:0]=(n*7+1)&0xF and uo_out[7:4]=((31-n)*7+1)&0xF for all n.
- Read-during-write: mem[5]=0x2; set addrA=5, addrB=5, wdata=0x7, we=1:
  - Before the edge -> uo_out=0x22.
  - After the edge -> uo_out=0x77.
  - With DFFRAM_REGISTERED_READ_EN: 0x22 appears after the write edge, 0x77 one clock later.
- Write gating: ena=0, we=1, addrA=9, wdata=0xF, clock; then ena=1, we=0 -> read addr 9 still returns its prior value (0x0 after reset). Repeat with ena=1, we=0 -> no change.
- Reset mid-operation: write 0xC to addr 12; assert rst_n=0 with we=1 and wdata=0x5 on addr 12 for one clock; release -> read addr 12 = 0x0 (reset wins over write).

Source files
------------

// File: rtl/dffram_32x4_2r1w_if.sv
// Tile pin bundle for dffram_32x4_2r1w (TinyTapeout user tile pins).
// The master drives enable and the input pins; the slave (the RAM) drives outputs.
interface dffram_32x4_2r1w_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/dffram_32x4_2r1w.sv
// dffram_32x4_2r1w: 32 x 4-bit flip-flop RAM, two read ports (A, B), one write
// port sharing address A, packed behind TinyTapeout tile pins.
// Optional macro DFFRAM_REGISTERED_READ_EN: reads go through an 8-bit output
// register (1-cycle latency, read-before-write). Default build reads are
// combinational.
module dffram_32x4_2r1w #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    dffram_32x4_2r1w_if.slave   bus
);

    logic [ADDR_W-1:0]             addr_a;
    logic [ADDR_W-1:0]             addr_b;
    logic [DATA_W-1:0]             wdata;
    logic                          we;
    logic                          wr_en;
    logic [DATA_W-1:0]             rd_a;
    logic [DATA_W-1:0]             rd_b;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_d;
    logic                          unused_uio7;

    // Pin unpacking: address B is split across ui_in[7:5] and uio_in[1:0].
    assign addr_a      = bus.ui_in[4:0];
    assign addr_b      = {bus.uio_in[1:0], bus.ui_in[7:5]};
    assign wdata       = bus.uio_in[5:2];
    assign we          = bus.uio_in[6];
    assign wr_en       = bus.ena & we;
    assign unused_uio7 = bus.uio_in[7];

    // uio pins are inputs only, in every state including reset.
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    // Next-state of the array: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[addr_a] = wdata;
        end
    end

    // Storage update; reset clears every word and overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Both read ports index the stored array directly; no wdata bypass.
    assign rd_a = mem_q[addr_a];
    assign rd_b = mem_q[addr_b];

`ifdef DFFRAM_REGISTERED_READ_EN
    logic [7:0] dout_q;
    logic [7:0] dout_d;

    assign dout_d = {rd_b, rd_a};

    // Output register samples the pre-write array contents every edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= 8'h00;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.uo_out = dout_q;
`else
    assign bus.uo_out = {rd_b, rd_a};
`endif

endmodule

// File: tb/tb_dffram_32x4_2r1w.sv
// Testbench for dffram_32x4_2r1w: directed steps, expected read data queued
// when a read is driven and compared when the DUT presents it. Works for both
// the combinational and the DFFRAM_REGISTERED_READ_EN builds.
module tb_dffram_32x4_2r1w;

    logic clk;
    logic rst_n;

    dffram_32x4_2r1w_if bus ();

    dffram_32x4_2r1w dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [3:0] model [32];
    logic [7:0] exp_q [$];
    string      tag_q [$];

    logic       cur_ena;
    logic       cur_we;
    logic [4:0] cur_a;
    logic [4:0] cur_b;
    logic [3:0] cur_wd;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check8(t, bus.uo_out, e);
    endtask

    task automatic set_in(input logic ena, input logic we, input logic [4:0] a,
                          input logic [4:0] b, input logic [3:0] wd, input logic u7);
        cur_ena = ena;
        cur_we  = we;
        cur_a   = a;
        cur_b   = b;
        cur_wd  = wd;
        bus.ena    = ena;
        bus.ui_in  = {b[2:0], a};
        bus.uio_in = {u7, we, wd, b[4:3]};
    endtask

    // One clock cycle, entered and left at a falling edge. The expected read
    // is the pre-edge word pair; it shows before the edge in the combinational
    // build and just after the edge in the registered build.
    task automatic cycle(input string tag, input bit chk);
        if (chk) begin
            exp_q.push_back({model[cur_b], model[cur_a]});
            tag_q.push_back(tag);
        end
`ifndef DFFRAM_REGISTERED_READ_EN
        #1;
        if (chk) pop_check();
`endif
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 4'h0;
        end else if (cur_ena && cur_we) begin
            model[cur_a] = cur_wd;
        end
`ifdef DFFRAM_REGISTERED_READ_EN
        #1;
        if (chk) pop_check();
`endif
        #1;
        check8({tag, "_uio_out"}, bus.uio_out, 8'h00);
        check8({tag, "_uio_oe"}, bus.uio_oe, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 4'hx;
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 5'd7, 5'd9, 4'h3, 1'b0);
        @(negedge clk);

        // Reset held for two clocks (with a write request that must be ignored).
        cycle("reset0", 1'b0);
        cycle("reset1", 1'b0);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 5'd0, 5'd31, 4'h0, 1'b0);
        cycle("post_reset", 1'b1);

        // Single write then dual read of the same word.
        set_in(1'b1, 1'b1, 5'd3, 5'd0, 4'hA, 1'b0);
        cycle("wr3", 1'b0);
        set_in(1'b1, 1'b0, 5'd3, 5'd3, 4'h0, 1'b1);
        cycle("rd3_both", 1'b1);

        // Fill every word, then sweep both ports in opposite directions.
        for (int n = 0; n < 32; n++) begin
            set_in(1'b1, 1'b1, 5'(n), 5'(31 - n), 4'((n * 7 + 1) & 15), 1'(n & 1));
            cycle("fill", 1'b0);
        end
        for (int n = 0; n < 32; n++) begin
            set_in(1'b1, 1'b0, 5'(n), 5'(31 - n), 4'hF, 1'(n & 1));
            cycle($sformatf("sweep%0d", n), 1'b1);
        end

        // Read-during-write at address 5: old word before edge, new word after.
        set_in(1'b1, 1'b1, 5'd5, 5'd0, 4'h2, 1'b0);
        cycle("wr5_init", 1'b0);
        set_in(1'b1, 1'b1, 5'd5, 5'd5, 4'h7, 1'b0);
        cycle("rdw_old", 1'b1);
        set_in(1'b1, 1'b0, 5'd5, 5'd5, 4'h0, 1'b0);
        cycle("rdw_new", 1'b1);

        // Write gating: ena=0 blocks a write, we=0 blocks a write.
        set_in(1'b0, 1'b1, 5'd9, 5'd9, 4'hF, 1'b1);
        cycle("gate_ena", 1'b0);
        set_in(1'b1, 1'b0, 5'd9, 5'd9, 4'hF, 1'b0);
        cycle("gate_ena_rd", 1'b1);
        set_in(1'b1, 1'b0, 5'd9, 5'd8, 4'hF, 1'b1);
        cycle("gate_we", 1'b0);
        set_in(1'b1, 1'b0, 5'd9, 5'd8, 4'h0, 1'b0);
        cycle("gate_we_rd", 1'b1);

        // Reset mid-operation wins over a same-cycle write.
        set_in(1'b1, 1'b1, 5'd12, 5'd3, 4'hC, 1'b0);
        cycle("wr12", 1'b0);
        set_in(1'b1, 1'b0, 5'd12, 5'd3, 4'h0, 1'b0);
        cycle("rd12_pre", 1'b1);
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 5'd12, 5'd3, 4'h5, 1'b0);
        cycle("mid_reset", 1'b0);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 5'd12, 5'd3, 4'h0, 1'b0);
        cycle("rd12_post", 1'b1);
        set_in(1'b1, 1'b0, 5'd31, 5'd5, 4'h0, 1'b0);
        cycle("rd_cleared", 1'b1);

        check8("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
